// File: rtl/serial_add_seq_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// The DUT uses the slave modport and the operand source/result sink uses the master modport.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder, one bit per clock and LSB first; result is valid WIDTH cycles after accept.
// Holds the result in DONE until out_ready; in_valid is ignored unless the block is idle.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, ssum;
    logic             carry, cmsb_in;
    logic [CW-1:0]    cnt;
    logic             in_ready, out_valid;
    logic             s_bit, c_bit;
    logic [1:0]       ha0, ha1;

    // Returns {carry, sum}.
    function automatic logic [1:0] half_adder(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    always_comb begin
        ha0   = half_adder(sa[0], sb[0]);
        ha1   = half_adder(ha0[0], carry);
        s_bit = ha1[0];
        c_bit = ha0[1] | ha1[1];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            ssum    <= '0;
            carry   <= 1'b0;
            cmsb_in <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    ssum  <= {s_bit, ssum[WIDTH-1:1]};
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    carry <= c_bit;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_PREV) cmsb_in <= c_bit;
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = !in_ready;
    assign bus.sum       = ssum;
    assign bus.cout      = carry;
    assign bus.ovf       = cmsb_in ^ carry;
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add sequencer for the uart2ahb datapath. It time-shares a single 1-bit full-adder stage, built from two `half_adder` cells plus an OR for carry, across a WIDTH-bit addition, one bit per clock, LSB first. It accepts operands on a valid/ready handshake and returns sum, carry-out and signed overflow on a second valid/ready handshake. It serves address and length arithmetic where area matters more than latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a/b/cin valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  WIDTH  operand A, sampled on input handshake
- b  in  WIDTH  operand B, sampled on input handshake
- cin  in  1  carry-in, sampled on input handshake
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is implementation choice.
- IDLE: in_ready=1. On in_valid&in_ready at an edge:
  - load shift regs sa<=a and sb<=b
  - carry<=cin, bit counter cnt<=0
  - next state RUN
- RUN: each edge computes s = sa[0]^sb[0]^carry and c = majority(sa[0],sb[0],carry).
  - ssum shifts right with s into bit WIDTH-1; sa and sb shift right; carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-2 is processed, capture the incoming carry as cmsb_in (carry into the MSB).
  - On the edge processing cnt==WIDTH-1, go to DONE.
- DONE: out_valid=1. sum=ssum, cout=carry, ovf=cmsb_in^carry. Outputs are stable while out_valid&!out_ready.
  - On out_valid&out_ready, go to IDLE.
- in_valid outside IDLE is ignored; operands are not queued. No input/output pass-through: the earliest next accept is the cycle after the output handshake.
- sum/cout/ovf hold their last values in IDLE until the next DONE. Only the out_valid qualification is meaningful.
- cnt width is $clog2(WIDTH). It wraps only via reload on accept.
- The adder stage is purely combinational. All state is registered on clk.

## Timing
- Reset (rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, cnt=0, carry=0.
- Reset has priority over any handshake in the same cycle. Reset mid-RUN or in DONE discards the operation with no output handshake.
- Accept at edge E0. Bit i is processed at edge E(i+1). out_valid rises after edge E(WIDTH), so latency is WIDTH cycles from accept to out_valid.
- Minimum period per operation is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with out_ready=1.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- busy = !in_ready.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept. sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Separately a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stay constant and in_ready=0. Raising out_ready gives IDLE the next cycle, and the next accept succeeds.
- Hold in_valid=1 with changing a/b during RUN -> the result reflects only the operands captured at accept.
- Assert rst for 1 cycle after bit 3 is processed -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0. A new operation 0x10+0x20 then yields 0x30.
